storebuffer_queue: RTL and testbench
====================================

// Module: storebuffer_queue
// PURPOSE
// Parametrised posted-store queue between the core data port and dmem. Stores
// retire to the core after one cycle and drain to memory in order. Loads and
// fences are ordered against buffered stores. Optional forwarding lets
// non-overlapping loads overtake queued stores and serves full-word hits
// straight from the queue.
// PARAMETERS
// DEPTH_LOG2  2   queue holds 2**DEPTH_LOG2 entries
// XLEN        32  data width; strobe width XLEN/8
// AWIDTH      32  address width
// PORTS
// clock        in   1           rising-edge clock
// reset        in   1           synchronous, active-high
// cpu_valid    in   1           1-cycle request pulse; at most one request outstanding
// cpu_fence    in   1           request is a fence
// cpu_addr     in   AWIDTH      request address
// cpu_wdata    in   XLEN        store data
// cpu_wstrb    in   XLEN/8      !=0 store; ==0 load (full word)
// cpu_ready    out  1           1-cycle completion pulse
// cpu_rdata    out  XLEN        load data, valid with cpu_ready; 0 otherwise
// mem_valid    out  1           dmem request, held until mem_ready
// mem_fence    out  1           dmem fence request
// mem_addr     out  AWIDTH      dmem address
// mem_wdata    out  XLEN        dmem store data
// mem_wstrb    out  XLEN/8      dmem strobes; 0 = load
// mem_ready    in   1           dmem accept/complete; transfer when valid&ready
// mem_rdata    in   XLEN        dmem load data, sampled with mem_ready
// count        out  DEPTH_LOG2+1  occupied entries
// BEHAVIOUR
// - Reset: all outputs 0, wptr=rptr=0, pending request cleared; queue contents
//   and any in-flight dmem transaction are abandoned (dmem resets with us).
// - Pointers are DEPTH_LOG2+1 bits. Empty: wptr==rptr. Full: pointers differ
//   only in the MSB. Wrap from 2**DEPTH_LOG2-1 to 0 toggles the MSB.
// - Request latch: cpu_valid captures fence/addr/wdata/wstrb into a pending
//   register. The core issues no new request before cpu_ready.
// - Store, not full: entry {wstrb,addr,wdata} is written at wptr. cpu_ready
//   pulses the cycle after cpu_valid. count increments.
// - Store, full: stays pending and cpu_ready is withheld. It is written in the
//   same cycle a pop frees a slot (count unchanged that cycle). cpu_ready
//   follows one cycle later.
// - Drain: one dmem transaction outstanding at a time. When dmem is idle,
//   priority is eligible load > queue head > fence. Head pops (rptr++) on
//   mem_ready. A push and a pop in one cycle leave count unchanged.
// - Load: issued with mem_wstrb=0 once eligible. cpu_rdata=mem_rdata and
//   cpu_ready pulse the cycle after mem_ready.
// - Fence: waits until the queue is empty and dmem is idle. Then mem_valid and
//   mem_fence are driven until mem_ready. cpu_ready pulses the next cycle.
// - mem_* are registered; addr/wdata/wstrb stay stable while mem_valid=1.
// - Overlap compare uses addr[AWIDTH-1:$clog2(XLEN/8)] against all valid entries.
// CONFIGURATION
// STOREBUFFER_FORWARD_EN defined:
//   - A load with no overlapping entry is eligible immediately and overtakes
//     queued stores.
//   - If the youngest overlapping entry has all strobes set, its data returns
//     with cpu_ready the cycle after cpu_valid; no dmem access.
//   - If it is a partial overlap, the load waits until no overlapping entry
//     remains.
// STOREBUFFER_FORWARD_EN undefined: a load becomes eligible only when the queue
//   is empty and dmem is idle; no compare logic is built.
// TESTING
// - Reset then 4 stores (DEPTH_LOG2=2) to 0x100..0x10C with mem_ready held 0
//   -> cpu_ready each time +1 cycle, count=4, mem_valid=1 with addr 0x100.
// - Full queue plus 5th store, then mem_ready pulse -> 5th store written in the
//   pop cycle, count stays 4, cpu_ready 1 cycle later; drain order 0x100..0x110;
//   pointers wrap to 0 with the MSB toggled.
// - Fence with 2 queued stores -> mem_fence only after both pops; cpu_ready the
//   cycle after the fence's mem_ready.
// - [FORWARD_EN] store 0xDEADBEEF wstrb=F to 0x200, dmem stalled, load 0x200
//   -> cpu_rdata=0xDEADBEEF +1 cycle, no dmem load.
// - [FORWARD_EN] queued store wstrb=0x3 to 0x200, load 0x200 -> no issue until
//   the store pops. A load to 0x300 issues ahead of queued stores.
//   [undefined] the same load waits for empty.
// - Reset asserted mid-drain -> next cycle mem_valid=0, count=0, cpu_ready=0.

Source files
------------

// File: rtl/storebuffer_queue_if.sv
// Core request/response and dmem bus bundle for storebuffer_queue.
// slave is the queue's view; master is the core+dmem environment's view.
interface storebuffer_queue_if #(
    parameter int XLEN   = 32,
    parameter int AWIDTH = 32
);
    logic              cpu_valid;
    logic              cpu_fence;
    logic [AWIDTH-1:0] cpu_addr;
    logic [XLEN-1:0]   cpu_wdata;
    logic [XLEN/8-1:0] cpu_wstrb;
    logic              cpu_ready;
    logic [XLEN-1:0]   cpu_rdata;
    logic              mem_valid;
    logic              mem_fence;
    logic [AWIDTH-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_rdata;

    modport slave (
        input  cpu_valid, cpu_fence, cpu_addr, cpu_wdata, cpu_wstrb, mem_ready, mem_rdata,
        output cpu_ready, cpu_rdata, mem_valid, mem_fence, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output cpu_valid, cpu_fence, cpu_addr, cpu_wdata, cpu_wstrb, mem_ready, mem_rdata,
        input  cpu_ready, cpu_rdata, mem_valid, mem_fence, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/storebuffer_queue.sv
// Posted-store queue between core data port and dmem; in-order drain, ordered loads/fences.
// Define STOREBUFFER_FORWARD_EN to let non-overlapping loads overtake and full-word hits forward.
module storebuffer_queue #(
    parameter int DEPTH_LOG2 = 2,
    parameter int XLEN       = 32,
    parameter int AWIDTH     = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    storebuffer_queue_if.slave    bus,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SW    = XLEN / 8;

    typedef logic [DEPTH_LOG2:0] ptr_t;

    logic [AWIDTH-1:0] entry_addr_q [DEPTH];
    logic [XLEN-1:0]   entry_data_q [DEPTH];
    logic [SW-1:0]     entry_strb_q [DEPTH];

    ptr_t              wptr_q, wptr_d, rptr_q, rptr_d;
    logic              pend_q, pend_d;
    logic              pend_fence_q, pend_fence_d;
    logic [AWIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [XLEN-1:0]   pend_wdata_q, pend_wdata_d;
    logic [SW-1:0]     pend_wstrb_q, pend_wstrb_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_fence_q, mem_fence_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [SW-1:0]     mem_wstrb_q, mem_wstrb_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic [XLEN-1:0]   cpu_rdata_q, cpu_rdata_d;

    logic              req_v, req_fence, req_store, req_load;
    logic [AWIDTH-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [SW-1:0]     req_wstrb;
    logic              empty, full, mem_done, pop, push;
    logic              load_go, fwd_hit;
    logic [XLEN-1:0]   fwd_data;
    logic [DEPTH_LOG2-1:0] head;

    // A fresh request is acted on in its own cycle; otherwise the latched copy is retried.
    assign req_v     = bus.cpu_valid | pend_q;
    assign req_fence = bus.cpu_valid ? bus.cpu_fence : pend_fence_q;
    assign req_addr  = bus.cpu_valid ? bus.cpu_addr  : pend_addr_q;
    assign req_wdata = bus.cpu_valid ? bus.cpu_wdata : pend_wdata_q;
    assign req_wstrb = bus.cpu_valid ? bus.cpu_wstrb : pend_wstrb_q;
    assign req_store = req_v & ~req_fence & (req_wstrb != '0);
    assign req_load  = req_v & ~req_fence & (req_wstrb == '0);

    assign count    = wptr_q - rptr_q;
    assign empty    = (wptr_q == rptr_q);
    assign full     = ((wptr_q ^ rptr_q) == {1'b1, {DEPTH_LOG2{1'b0}}});
    assign head     = rptr_q[DEPTH_LOG2-1:0];
    assign mem_done = mem_valid_q & bus.mem_ready;
    assign pop      = mem_done & (mem_wstrb_q != '0);
    assign push     = req_store & (~full | pop);

`ifdef STOREBUFFER_FORWARD_EN
    localparam int LSB = $clog2(SW);

    logic              ovl_any, ovl_full;
    logic [XLEN-1:0]   ovl_data;
    logic [DEPTH_LOG2-1:0] idx;

    // Walk oldest to youngest so the last match left standing is the youngest entry.
    always_comb begin
        ovl_any  = 1'b0;
        ovl_full = 1'b0;
        ovl_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + DEPTH_LOG2'(i);
            if ((ptr_t'(i) < count) &&
                (entry_addr_q[idx][AWIDTH-1:LSB] == req_addr[AWIDTH-1:LSB])) begin
                ovl_any  = 1'b1;
                ovl_full = &entry_strb_q[idx];
                ovl_data = entry_data_q[idx];
            end
        end
    end

    assign fwd_hit  = req_load & ovl_full;
    assign fwd_data = ovl_data;
    assign load_go  = req_load & ~ovl_any & ~mem_valid_q;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
    assign load_go  = req_load & empty & ~mem_valid_q;
`endif

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        pend_d       = req_v;
        pend_fence_d = req_fence;
        pend_addr_d  = req_addr;
        pend_wdata_d = req_wdata;
        pend_wstrb_d = req_wstrb;
        mem_valid_d  = mem_valid_q;
        mem_fence_d  = mem_fence_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        cpu_ready_d  = 1'b0;
        cpu_rdata_d  = '0;

        if (mem_done) begin
            mem_valid_d = 1'b0;
            mem_fence_d = 1'b0;
            if (pop) begin
                rptr_d = rptr_q + ptr_t'(1);
            end else begin
                cpu_ready_d = 1'b1;
                if (!mem_fence_q) begin
                    cpu_rdata_d = bus.mem_rdata;
                end
            end
        end

        if (push) begin
            wptr_d      = wptr_q + ptr_t'(1);
            pend_d      = 1'b0;
            cpu_ready_d = 1'b1;
        end

        if (fwd_hit) begin
            pend_d      = 1'b0;
            cpu_ready_d = 1'b1;
            cpu_rdata_d = fwd_data;
        end

        // Idle dmem: eligible load first, then the queue head, then a fence once drained.
        if (!mem_valid_q) begin
            if (load_go) begin
                pend_d      = 1'b0;
                mem_valid_d = 1'b1;
                mem_fence_d = 1'b0;
                mem_addr_d  = req_addr;
                mem_wdata_d = '0;
                mem_wstrb_d = '0;
            end else if (!empty) begin
                mem_valid_d = 1'b1;
                mem_fence_d = 1'b0;
                mem_addr_d  = entry_addr_q[head];
                mem_wdata_d = entry_data_q[head];
                mem_wstrb_d = entry_strb_q[head];
            end else if (req_v && req_fence) begin
                pend_d      = 1'b0;
                mem_valid_d = 1'b1;
                mem_fence_d = 1'b1;
                mem_addr_d  = req_addr;
                mem_wdata_d = '0;
                mem_wstrb_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            pend_q      <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_fence_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            pend_q      <= pend_d;
            mem_valid_q <= mem_valid_d;
            mem_fence_q <= mem_fence_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    always_ff @(posedge clock) begin
        pend_fence_q <= pend_fence_d;
        pend_addr_q  <= pend_addr_d;
        pend_wdata_q <= pend_wdata_d;
        pend_wstrb_q <= pend_wstrb_d;
        if (push) begin
            entry_addr_q[wptr_q[DEPTH_LOG2-1:0]] <= req_addr;
            entry_data_q[wptr_q[DEPTH_LOG2-1:0]] <= req_wdata;
            entry_strb_q[wptr_q[DEPTH_LOG2-1:0]] <= req_wstrb;
        end
    end

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_fence = mem_fence_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.cpu_ready = cpu_ready_q;
    assign bus.cpu_rdata = cpu_rdata_q;
endmodule

// File: tb/tb_storebuffer_queue.sv
// Directed bench for storebuffer_queue (DEPTH_LOG2=2); forwarding expectations follow STOREBUFFER_FORWARD_EN.
module tb_storebuffer_queue;
    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] count;
    int         n_tests = 0;
    int         n_fail  = 0;

    storebuffer_queue_if #(.XLEN(32), .AWIDTH(32)) bus ();

    storebuffer_queue #(.DEPTH_LOG2(2), .XLEN(32), .AWIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .count (count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_idle();
        bus.cpu_valid = 1'b0;
        bus.cpu_fence = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_wstrb = '0;
    endtask

    task automatic cpu_req(input logic fence, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
        bus.cpu_valid = 1'b1;
        bus.cpu_fence = fence;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = data;
        bus.cpu_wstrb = strb;
        tick();
        cpu_idle();
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        cpu_req(1'b0, addr, data, strb);
        chk("store_ready", bus.cpu_ready, 1);
    endtask

    task automatic mem_ack(input logic [31:0] rdata);
        bus.mem_rdata = rdata;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic wait_mem();
        for (int i = 0; i < 20 && !bus.mem_valid; i++) tick();
        chk("mem_issue", bus.mem_valid, 1);
    endtask

    task automatic drain(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        wait_mem();
        chk("drain_addr", bus.mem_addr, addr);
        chk("drain_data", bus.mem_wdata, data);
        chk("drain_strb", bus.mem_wstrb, strb);
        mem_ack(32'h0);
    endtask

    initial begin
        reset = 1'b1;
        cpu_idle();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        tick();
        tick();
        chk("rst_count", count, 0);
        chk("rst_mem_valid", bus.mem_valid, 0);
        chk("rst_cpu_ready", bus.cpu_ready, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        reset = 1'b0;
        tick();

        // Fill the queue with dmem stalled
        store(32'h100, 32'hA5A5_0100, 4'hF);
        chk("fill1_count", count, 1);
        chk("fill1_mem_valid", bus.mem_valid, 0);
        store(32'h104, 32'hA5A5_0104, 4'hF);
        chk("fill2_count", count, 2);
        chk("fill2_mem_addr", bus.mem_addr, 32'h100);
        store(32'h108, 32'hA5A5_0108, 4'hF);
        store(32'h10C, 32'hA5A5_010C, 4'hF);
        chk("full_count", count, 4);
        chk("full_mem_valid", bus.mem_valid, 1);
        chk("full_mem_addr", bus.mem_addr, 32'h100);
        chk("full_mem_wdata", bus.mem_wdata, 32'hA5A5_0100);
        chk("full_mem_wstrb", bus.mem_wstrb, 4'hF);
        chk("full_wptr", dut.wptr_q, 3'b100);
        chk("full_rptr", dut.rptr_q, 3'b000);

        // Fifth store against a full queue
        cpu_req(1'b0, 32'h110, 32'h5555_0110, 4'hF);
        chk("stall_ready0", bus.cpu_ready, 0);
        chk("stall_count", count, 4);
        tick();
        chk("stall_ready1", bus.cpu_ready, 0);
        mem_ack(32'h0);
        chk("popush_count", count, 4);
        chk("popush_ready", bus.cpu_ready, 1);
        chk("popush_mem_valid", bus.mem_valid, 0);
        tick();
        chk("popush_ready_drop", bus.cpu_ready, 0);
        drain(32'h104, 32'hA5A5_0104, 4'hF);
        drain(32'h108, 32'hA5A5_0108, 4'hF);
        drain(32'h10C, 32'hA5A5_010C, 4'hF);
        drain(32'h110, 32'h5555_0110, 4'hF);
        chk("wrap_count", count, 0);
        chk("wrap_wptr", dut.wptr_q, 3'b101);
        chk("wrap_rptr", dut.rptr_q, 3'b101);

        // Fence behind two queued stores
        store(32'h120, 32'h0000_0120, 4'hF);
        store(32'h124, 32'h0000_0124, 4'hF);
        cpu_req(1'b1, 32'h0, 32'h0, 4'h0);
        chk("fence_ready0", bus.cpu_ready, 0);
        chk("fence_early0", bus.mem_fence, 0);
        drain(32'h120, 32'h0000_0120, 4'hF);
        chk("fence_early1", bus.mem_fence, 0);
        drain(32'h124, 32'h0000_0124, 4'hF);
        chk("fence_early2", bus.mem_fence, 0);
        chk("fence_ready1", bus.cpu_ready, 0);
        tick();
        chk("fence_valid", bus.mem_valid, 1);
        chk("fence_flag", bus.mem_fence, 1);
        chk("fence_ready2", bus.cpu_ready, 0);
        mem_ack(32'h0);
        chk("fence_done", bus.cpu_ready, 1);
        chk("fence_drop", bus.mem_fence, 0);
        tick();
        chk("fence_ready_drop", bus.cpu_ready, 0);

        // Full-word store then load to the same word
        store(32'h200, 32'hDEAD_BEEF, 4'hF);
        cpu_req(1'b0, 32'h200, 32'h0, 4'h0);
`ifdef STOREBUFFER_FORWARD_EN
        chk("fwd_ready", bus.cpu_ready, 1);
        chk("fwd_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
        chk("fwd_no_load", bus.mem_wstrb, 4'hF);
        tick();
        chk("fwd_ready_drop", bus.cpu_ready, 0);
        chk("fwd_rdata_drop", bus.cpu_rdata, 0);
        drain(32'h200, 32'hDEAD_BEEF, 4'hF);
        tick();
        chk("fwd_idle", bus.mem_valid, 0);
`else
        chk("ld_wait_ready", bus.cpu_ready, 0);
        drain(32'h200, 32'hDEAD_BEEF, 4'hF);
        wait_mem();
        chk("ld_addr", bus.mem_addr, 32'h200);
        chk("ld_strb", bus.mem_wstrb, 4'h0);
        mem_ack(32'h1234_5678);
        chk("ld_ready", bus.cpu_ready, 1);
        chk("ld_rdata", bus.cpu_rdata, 32'h1234_5678);
        tick();
        chk("ld_ready_drop", bus.cpu_ready, 0);
`endif

        // Partial overlap: load must wait for the partial store to leave
        store(32'h200, 32'h0000_ABCD, 4'h3);
        store(32'h204, 32'h0000_0204, 4'hF);
        cpu_req(1'b0, 32'h200, 32'h0, 4'h0);
        chk("part_ready0", bus.cpu_ready, 0);
        chk("part_head_strb", bus.mem_wstrb, 4'h3);
        mem_ack(32'h0);
        chk("part_ready1", bus.cpu_ready, 0);
        tick();
`ifdef STOREBUFFER_FORWARD_EN
        chk("part_ld_addr", bus.mem_addr, 32'h200);
        chk("part_ld_strb", bus.mem_wstrb, 4'h0);
        mem_ack(32'h0BAD_F00D);
        chk("part_ld_ready", bus.cpu_ready, 1);
        chk("part_ld_rdata", bus.cpu_rdata, 32'h0BAD_F00D);
        drain(32'h204, 32'h0000_0204, 4'hF);
`else
        chk("part_head2_addr", bus.mem_addr, 32'h204);
        drain(32'h204, 32'h0000_0204, 4'hF);
        wait_mem();
        chk("part_ld_addr", bus.mem_addr, 32'h200);
        chk("part_ld_strb", bus.mem_wstrb, 4'h0);
        mem_ack(32'h0BAD_F00D);
        chk("part_ld_ready", bus.cpu_ready, 1);
        chk("part_ld_rdata", bus.cpu_rdata, 32'h0BAD_F00D);
`endif

        // Non-overlapping load versus queued stores
        store(32'h210, 32'h0000_0210, 4'hF);
        store(32'h214, 32'h0000_0214, 4'hF);
        cpu_req(1'b0, 32'h300, 32'h0, 4'h0);
        chk("ovt_ready0", bus.cpu_ready, 0);
        chk("ovt_head_addr", bus.mem_addr, 32'h210);
        mem_ack(32'h0);
        tick();
`ifdef STOREBUFFER_FORWARD_EN
        chk("ovt_ld_addr", bus.mem_addr, 32'h300);
        chk("ovt_ld_strb", bus.mem_wstrb, 4'h0);
        mem_ack(32'h3000_0300);
        chk("ovt_ld_ready", bus.cpu_ready, 1);
        chk("ovt_ld_rdata", bus.cpu_rdata, 32'h3000_0300);
        drain(32'h214, 32'h0000_0214, 4'hF);
`else
        chk("ovt_head2_addr", bus.mem_addr, 32'h214);
        drain(32'h214, 32'h0000_0214, 4'hF);
        wait_mem();
        chk("ovt_ld_addr", bus.mem_addr, 32'h300);
        chk("ovt_ld_strb", bus.mem_wstrb, 4'h0);
        mem_ack(32'h3000_0300);
        chk("ovt_ld_ready", bus.cpu_ready, 1);
        chk("ovt_ld_rdata", bus.cpu_rdata, 32'h3000_0300);
`endif

        // Reset while draining
        store(32'h400, 32'h0000_0400, 4'hF);
        store(32'h404, 32'h0000_0404, 4'hF);
        chk("mid_mem_valid", bus.mem_valid, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_mem_valid", bus.mem_valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ready", bus.cpu_ready, 0);
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_idle", bus.mem_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
